// File: rtl/iir_orde1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_orde1_pkg
// Description : Shared register offsets, CTRL bits, Q1.15 types/constants and
//               the saturation helper for the stereo first-order IIR block.
// Revision    : 1.0 - initial release
// ============================================================================
package iir_orde1_pkg;

    typedef logic signed [15:0] sample_t;

    localparam logic [3:0] ADDR_CTRL = 4'h0;
    localparam logic [3:0] ADDR_B0   = 4'h4;
    localparam logic [3:0] ADDR_B1   = 4'h8;
    localparam logic [3:0] ADDR_A1   = 4'hC;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam sample_t Q15_ONE  = 16'sd32767;
    localparam sample_t Q15_HALF = 16'sd16384;

    // Clamp a post-shift accumulator into the Q1.15 range.
    function automatic sample_t sat16(input logic signed [18:0] v);
        if (v > 19'sd32767) begin
            return Q15_ONE;
        end else if (v < -19'sd32768) begin
            return sample_t'(16'h8000);
        end else begin
            return v[15:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_orde1_channel.sv
`default_nettype none
// ============================================================================
// Module      : iir_orde1_channel
// Description : One channel of the first-order IIR: MAC, arithmetic shift,
//               saturation and the x1/y1 history registers.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_orde1_channel
    import iir_orde1_pkg::*;
(
    input  logic    aclk,
    input  logic    aresetn,
    input  logic    i_enable,
    input  logic    i_clear,
    input  logic    i_advance,
    input  sample_t i_x,
    input  sample_t i_b0,
    input  sample_t i_b1,
    input  sample_t i_a1,
    output sample_t o_y
);

    sample_t r_x1;
    sample_t r_y1;
    sample_t w_x1;
    sample_t w_y1;

    logic signed [31:0] w_p0;
    logic signed [31:0] w_p1;
    logic signed [31:0] w_p2;
    logic signed [33:0] w_acc;
    logic [14:0]        w_unused_acc;

    // A beat taken while CLEAR is held sees zero history.
    assign w_x1 = i_clear ? '0 : r_x1;
    assign w_y1 = i_clear ? '0 : r_y1;

    assign w_p0 = 32'(i_b0) * 32'(i_x);
    assign w_p1 = 32'(i_b1) * 32'(w_x1);
    assign w_p2 = 32'(i_a1) * 32'(w_y1);

    assign w_acc = {{2{w_p0[31]}}, w_p0}
                 + {{2{w_p1[31]}}, w_p1}
                 + {{2{w_p2[31]}}, w_p2};

    assign o_y          = sat16(w_acc[33:15]);
    assign w_unused_acc = w_acc[14:0];

    always_ff @(posedge aclk) begin
        if (!aresetn || i_clear) begin
            r_x1 <= '0;
            r_y1 <= '0;
        end else if (i_advance && i_enable) begin
            r_x1 <= i_x;
            r_y1 <= o_y;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iir_orde1_axis_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : iir_orde1_axis_wrapper
// Description : Stereo first-order IIR with AXI4-Stream data path and an
//               AXI4-Lite register file (CTRL, B0, B1, A1).
// Revision    : 1.0 - initial release
// ============================================================================
module iir_orde1_axis_wrapper
    import iir_orde1_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH         = 32
) (
    input  logic                            aclk,
    input  logic                            aresetn,

    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,

    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);

    localparam int         c_nchan    = DATA_WIDTH / 16;
    localparam logic [1:0] c_idx_ctrl = ADDR_CTRL[3:2];
    localparam logic [1:0] c_idx_b0   = ADDR_B0[3:2];
    localparam logic [1:0] c_idx_b1   = ADDR_B1[3:2];
    localparam logic [1:0] c_idx_a1   = ADDR_A1[3:2];

    logic [1:0] r_ctrl;
    sample_t    r_b0;
    sample_t    r_b1;
    sample_t    r_a1;

    logic                          r_awready;
    logic                          r_bvalid;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_mux;
    logic                          w_wr_fire;
    logic                          w_rd_fire;

    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [DATA_WIDTH-1:0] w_y;
    logic                  w_s_tready;
    logic                  w_accept;
    logic                  w_enable;
    logic                  w_clear;
    logic                  w_unused;

    function automatic sample_t merge_bytes(input sample_t old, input logic [15:0] d,
                                            input logic [1:0] be);
        sample_t v;
        v = old;
        if (be[0]) v[7:0]  = d[7:0];
        if (be[1]) v[15:8] = d[15:8];
        return v;
    endfunction

    assign w_enable = r_ctrl[CTRL_ENABLE_BIT];
    assign w_clear  = r_ctrl[CTRL_CLEAR_BIT];

    // ---------------- AXI4-Lite write channel ----------------
    assign w_wr_fire     = r_awready && s_axi_awvalid && s_axi_wvalid;
    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_awready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = 2'b00;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_ctrl    <= '0;
            r_b0      <= '0;
            r_b1      <= '0;
            r_a1      <= '0;
        end else begin
            r_awready <= s_axi_awvalid && s_axi_wvalid && !r_bvalid && !r_awready;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                case (s_axi_awaddr[3:2])
                    c_idx_ctrl: if (s_axi_wstrb[0]) r_ctrl <= s_axi_wdata[1:0];
                    c_idx_b0:   r_b0 <= merge_bytes(r_b0, s_axi_wdata[15:0], s_axi_wstrb[1:0]);
                    c_idx_b1:   r_b1 <= merge_bytes(r_b1, s_axi_wdata[15:0], s_axi_wstrb[1:0]);
                    c_idx_a1:   r_a1 <= merge_bytes(r_a1, s_axi_wdata[15:0], s_axi_wstrb[1:0]);
                    default:    ;
                endcase
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // ---------------- AXI4-Lite read channel ----------------
    assign w_rd_fire     = r_arready && s_axi_arvalid;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;

    always_comb begin
        w_rd_mux = '0;
        case (s_axi_araddr[3:2])
            c_idx_ctrl: w_rd_mux[1:0]  = r_ctrl;
            c_idx_b0:   w_rd_mux[15:0] = r_b0;
            c_idx_b1:   w_rd_mux[15:0] = r_b1;
            c_idx_a1:   w_rd_mux[15:0] = r_a1;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= s_axi_arvalid && !r_rvalid && !r_arready;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- Stream path ----------------
    assign w_s_tready    = !r_m_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && w_s_tready;
    assign s_axis_tready = w_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tlast  = r_m_tlast;

    // Lane 0 is the Right sample [15:0], lane 1 the Left sample [31:16].
    for (genvar i = 0; i < c_nchan; i++) begin : g_chan
        iir_orde1_channel u_chan (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .i_enable  (w_enable),
            .i_clear   (w_clear),
            .i_advance (w_accept),
            .i_x       (s_axis_tdata[16*i +: 16]),
            .i_b0      (r_b0),
            .i_b1      (r_b1),
            .i_a1      (r_a1),
            .o_y       (w_y[16*i +: 16])
        );
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_enable ? w_y : s_axis_tdata;
            r_m_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                        s_axi_wdata[C_S_AXI_DATA_WIDTH-1:16],
                        s_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:2]};

endmodule
`default_nettype wire

// File: tb/tb_iir_orde1_axis_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_orde1_axis_wrapper
// Description : Scoreboard bench for the stereo IIR: stream results against
//               hand-derived expected beats, plus AXI-Lite register checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_orde1_axis_wrapper;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    always #5 aclk = ~aclk;

    iir_orde1_axis_wrapper dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] st(input int l, input int r);
        logic [15:0] a;
        logic [15:0] b;
        a = 16'(l);
        b = 16'(r);
        return {a, b};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Output monitor: handshake completes at the next rising edge.
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            if (sb_q.size() == 0) begin
                check_value("sb_unexpected_beat", 32'(sb_q.size()), 32'd1);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                check_value("m_tdata", m_axis_tdata, e.data);
                check_value("m_tlast", 32'(m_axis_tlast), 32'(e.last));
            end
        end
    end

    task automatic axil_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        n = 0;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        while (!s_axi_awready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check_value("aw_timeout", 32'(n), 32'd0);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check_value("bvalid", 32'(s_axi_bvalid), 32'd1);
        check_value("bresp", 32'(s_axi_bresp), 32'd0);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic axil_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check_value("ar_timeout", 32'(n), 32'd0);
        tick();
        s_axi_arvalid = 1'b0;
        check_value("rvalid", 32'(s_axi_rvalid), 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    // Leaves tvalid asserted so consecutive calls stream back-to-back.
    task automatic send(input logic [31:0] d, input logic last, input logic [31:0] exp);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_value("s_tready_timeout", 32'(n), 32'd0);
        sb_q.push_back('{data: exp, last: last});
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        while (sb_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check_value(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic set_coefs(input int b0, input int b1, input int a1);
        axil_write(4'h4, 32'(b0), 4'hF);
        axil_write(4'h8, 32'(b1), 4'hF);
        axil_write(4'hC, 32'(a1), 4'hF);
        axil_write(4'h0, 32'd3, 4'hF);
        axil_write(4'h0, 32'd1, 4'hF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [31:0] beat_a;

        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        repeat (3) tick();

        check_value("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_value("rst_m_tdata", m_axis_tdata, 32'd0);
        check_value("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        check_value("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
        check_value("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
        check_value("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
        aresetn = 1'b1;
        tick();

        // Unity-gain pass-through
        set_coefs(32767, 0, 0);
        send(st(10000, -5000), 1'b0, st(9999, -5000));
        for (int i = 0; i < 4; i++) send(st(0, 0), i == 3, st(0, 0));
        drain("pt_drain");

        // One-pole low-pass, halving every beat
        set_coefs(16384, 0, 16384);
        send(st(10000, 10000), 1'b0, st(5000, 5000));
        send(st(0, 0), 1'b0, st(2500, 2500));
        send(st(0, 0), 1'b0, st(1250, 1250));
        send(st(0, 0), 1'b0, st(625, 625));
        send(st(0, 0), 1'b1, st(312, 312));
        drain("lp_drain");

        // Positive saturation on the second beat
        set_coefs(32767, 32767, 0);
        send(st(32767, 32767), 1'b0, st(32766, 32766));
        send(st(32767, 32767), 1'b1, st(32767, 32767));
        drain("sat_drain");

        // Bypass
        axil_write(4'h0, 32'd0, 4'hF);
        send(st(123, -456), 1'b1, st(123, -456));
        drain("byp_drain");

        // Backpressure: hold the output for three cycles
        m_axis_tready = 1'b0;
        beat_a        = st(1111, -2222);
        s_axis_tdata  = beat_a;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        check_value("bp_ready_idle", 32'(s_axis_tready), 32'd1);
        sb_q.push_back('{data: beat_a, last: 1'b0});
        tick();
        s_axis_tdata = st(3333, -4444);
        s_axis_tlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_value("bp_m_tvalid", 32'(m_axis_tvalid), 32'd1);
            check_value("bp_m_tdata", m_axis_tdata, beat_a);
            check_value("bp_s_tready", 32'(s_axis_tready), 32'd0);
            tick();
        end
        sb_q.push_back('{data: st(3333, -4444), last: 1'b1});
        m_axis_tready = 1'b1;
        tick();
        drain("bp_drain");

        // AXI-Lite byte strobes, upper-half masking and CTRL readback
        axil_write(4'h8, 32'h0000_0000, 4'hF);
        axil_write(4'h8, 32'hABCD_1234, 4'h1);
        axil_read(4'h8, rd, rr);
        check_value("b1_strb_read", rd, 32'h0000_0034);
        axil_write(4'h4, 32'hFFFF_8000, 4'hF);
        axil_read(4'h4, rd, rr);
        check_value("b0_upper_masked", rd, 32'h0000_8000);
        axil_write(4'h0, 32'hFFFF_FFFF, 4'hF);
        axil_read(4'h0, rd, rr);
        check_value("ctrl_read", rd, 32'h0000_0003);
        check_value("ctrl_rresp", 32'(rr), 32'd0);

        // Reset while a beat sits in the output register
        axil_write(4'h0, 32'd1, 4'hF);
        m_axis_tready = 1'b0;
        s_axis_tdata  = st(777, 888);
        s_axis_tvalid = 1'b1;
        tick();
        check_value("mid_m_tvalid_pre", 32'(m_axis_tvalid), 32'd1);
        aresetn = 1'b0;
        tick();
        check_value("mid_m_tvalid_post", 32'(m_axis_tvalid), 32'd0);
        aresetn       = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            axil_read(4'(a * 4), rd, rr);
            check_value("post_rst_reg", rd, 32'd0);
        end
        check_value("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
